// File: rtl/kernel_kcore_start_arbiter.sv
// Round-robin arbiter sharing one start FIFO among several kcore producers.
// Credit-tracks FIFO occupancy and supports a flush/drain handshake.
module kernel_kcore_start_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_start_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 fifo_write_o,
  output logic [ID_WIDTH-1:0]  fifo_din_o,
  input  logic                 fifo_full_n_i,
  input  logic                 fifo_read_obs_i,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic [CNT_WIDTH-1:0] outstanding_o,
  output logic                 busy_o
);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 can_grant, found, grant;
  logic [ID_WIDTH-1:0]  winner;
  logic [ID_WIDTH:0]    idx;

  // Search from ptr upward, wrapping modulo NUM_REQ; first set bit wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (ID_WIDTH+1)'(ptr_q) + (ID_WIDTH+1)'(i);
      if (idx >= (ID_WIDTH+1)'(NUM_REQ)) begin
        idx = idx - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (!found && req_start_i[idx[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign can_grant = (state_q == StRun) && fifo_full_n_i && (cnt_q < CNT_WIDTH'(DEPTH));
  assign grant     = can_grant && found;

  always_comb begin
    req_ready_o  = '0;
    fifo_write_o = 1'b0;
    fifo_din_o   = '0;
    ptr_d        = ptr_q;
    if (grant) begin
      req_ready_o  = NUM_REQ'(1) << winner;
      fifo_write_o = 1'b1;
      fifo_din_o   = winner;
      ptr_d        = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + ID_WIDTH'(1);
    end
  end

  // A pop seen at zero occupancy is a protocol error; the count saturates.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({grant, fifo_read_obs_i})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = (cnt_q != '0) ? cnt_q - CNT_WIDTH'(1) : cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    unique case (state_q)
      StRun: begin
        if (flush_i) state_d = StDrain;
      end
      StDrain: begin
        if (cnt_q == '0) begin
          flush_done_o = 1'b1;
          state_d      = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = (state_q == StDrain) || (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StRun;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
